// File: rtl/mnist_pool_pkg.sv
// Shared constants and the per-sample max helper for the pooling stages.
package mnist_pool_pkg;
  localparam int POOL_K      = 2;
  localparam int POOL_STRIDE = 2;
  localparam int VMAX_W      = 32;

  // Callers widen samples to VMAX_W first (sign- or zero-extended to match sgn).
  function automatic logic [VMAX_W-1:0] vmax(input logic [VMAX_W-1:0] a, input logic [VMAX_W-1:0] b,
                                             input logic sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/max_pool_cmp.sv
// CH-lane combinational max of two packed pixel vectors (DATA_W < 32).
module max_pool_cmp
  import mnist_pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int SIGNED = 0
) (
  input  logic [CH-1:0][DATA_W-1:0] a,
  input  logic [CH-1:0][DATA_W-1:0] b,
  output logic [CH-1:0][DATA_W-1:0] y
);
  localparam logic SG = (SIGNED != 0);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic [VMAX_W-1:0] ax, bx;
    assign ax   = {{(VMAX_W-DATA_W){SG & a[i][DATA_W-1]}}, a[i]};
    assign bx   = {{(VMAX_W-DATA_W){SG & b[i][DATA_W-1]}}, b[i]};
    assign y[i] = (vmax(ax, bx, SG) == ax) ? a[i] : b[i];
  end
endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 max pool: pair register, half-width row buffer of pair maxima,
// one registered pooled vector per completed window.
module max_pool_stream
  import mnist_pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 valid_in,
  input  logic [CH*DATA_W-1:0] pixel_in,
  output logic                 valid_out,
  output logic [CH*DATA_W-1:0] pool_out,
  output logic                 frame_done
);
  localparam int PW = IMG_W / POOL_STRIDE;
  localparam int PH = IMG_H / POOL_STRIDE;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  typedef logic [CH-1:0][DATA_W-1:0] vec_t;

  vec_t          pix, pair_q, pair_max, rb_rd, win_max;
  vec_t          rowbuf [PW];
  logic [CW-1:0] col, c_eff;
  logic [RW-1:0] row, r_eff;
  logic [AW-1:0] addr;
  logic          pool_beat, emit, last_col, last_row;

  // clr with valid_in makes this beat pixel (0,0) of a fresh frame.
  assign pix       = pixel_in;
  assign c_eff     = clr ? '0 : col;
  assign r_eff     = clr ? '0 : row;
  assign addr      = AW'(c_eff >> 1);
  assign pool_beat = valid_in & c_eff[0] & (int'(c_eff) < POOL_K*PW) & (int'(r_eff) < POOL_K*PH);
  assign emit      = pool_beat & r_eff[0];
  assign last_col  = (int'(c_eff) == POOL_K*PW-1);
  assign last_row  = (int'(r_eff) == POOL_K*PH-1);
  assign rb_rd     = rowbuf[addr];

  max_pool_cmp #(.DATA_W(DATA_W), .CH(CH), .SIGNED(SIGNED)) u_pair (
    .a(pair_q), .b(pix), .y(pair_max)
  );
  max_pool_cmp #(.DATA_W(DATA_W), .CH(CH), .SIGNED(SIGNED)) u_win (
    .a(pair_max), .b(rb_rd), .y(win_max)
  );

  // Datapath storage needs no reset: every read follows a write in the same frame.
  always_ff @(posedge clk) begin
    if (valid_in & ~c_eff[0]) pair_q <= pix;
    if (pool_beat & ~r_eff[0]) rowbuf[addr] <= pair_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pool_out   <= '0;
    end else begin
      valid_out  <= emit;
      frame_done <= emit & last_col & last_row;
      if (emit) pool_out <= win_max;
      if (valid_in) begin
        if (c_eff == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (r_eff == RW'(IMG_H-1)) ? '0 : r_eff + 1'b1;
        end else begin
          col <= c_eff + 1'b1;
          row <= r_eff;
        end
      end else if (clr) begin
        col <= '0;
        row <= '0;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_stream.sv
// Directed + randomized bench for max_pool_stream over four parameter sets, checked against a raster-image model.
module tb_max_pool_stream;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  always #5 clk = ~clk;

  logic       vin0 = 0, vin1 = 0, vin2 = 0, vin3 = 0;
  logic [7:0] pin0 = 0, pin1 = 0, pin2 = 0;
  logic [1:0] pin3 = 0;
  logic       vo0, vo1, vo2, vo3, fd0, fd1, fd2, fd3;
  logic [7:0] po0, po1, po2;
  logic [1:0] po3;

  max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(vin0), .pixel_in(pin0),
    .valid_out(vo0), .pool_out(po0), .frame_done(fd0));
  max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(vin1), .pixel_in(pin1),
    .valid_out(vo1), .pool_out(po1), .frame_done(fd1));
  max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(5), .IMG_H(5), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(vin2), .pixel_in(pin2),
    .valid_out(vo2), .pool_out(po2), .frame_done(fd2));
  max_pool_stream #(.DATA_W(1), .CH(2), .IMG_W(2), .IMG_H(2), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(vin3), .pixel_in(pin3),
    .valid_out(vo3), .pool_out(po3), .frame_done(fd3));

  int W [4]  = '{4, 4, 5, 2};
  int H [4]  = '{4, 4, 5, 2};
  int SG [4] = '{0, 1, 0, 0};
  int tests = 0, fails = 0, cur = 0;
  logic [7:0] img [5][5];
  logic [7:0] last [4];
  logic [7:0] outs [$];
  logic       obs_v, obs_fd;
  logic [7:0] obs_p;

  always_comb begin
    obs_v = 1'b0; obs_fd = 1'b0; obs_p = 8'h00;
    case (cur)
      0: begin obs_v = vo0; obs_fd = fd0; obs_p = po0; end
      1: begin obs_v = vo1; obs_fd = fd1; obs_p = po1; end
      2: begin obs_v = vo2; obs_fd = fd2; obs_p = po2; end
      default: begin obs_v = vo3; obs_fd = fd3; obs_p = {6'h00, po3}; end
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  // Max of two samples as the pooling rule defines it; the CH=2/1-bit instance pools each bit independently.
  function automatic logic [7:0] m2(input logic [7:0] a, input logic [7:0] b, input int k);
    if (k == 3) return a | b;
    if (SG[k] != 0) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [7:0] p);
    case (k)
      0: begin vin0 = v; pin0 = p; end
      1: begin vin1 = v; pin1 = p; end
      2: begin vin2 = v; pin2 = p; end
      default: begin vin3 = v; pin3 = p[1:0]; end
    endcase
  endtask

  task automatic fill_seq(input int k);
    for (int r = 0; r < H[k]; r++)
      for (int c = 0; c < W[k]; c++) img[r][c] = 8'(r * W[k] + c);
  endtask

  task automatic fill_rand(input int k);
    for (int r = 0; r < H[k]; r++)
      for (int c = 0; c < W[k]; c++) img[r][c] = (k == 3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
  endtask

  task automatic idle_chk();
    if (obs_v === 1'b1) outs.push_back(obs_p);
    chk("idle_valid", obs_v, 0);
    chk("idle_fdone", obs_fd, 0);
    chk("hold_pool", obs_p, last[cur]);
  endtask

  // mode 0: back-to-back beats, 1: one idle cycle between beats, 2: random 0..2 idle cycles.
  task automatic run(input int k, input int mode, input int nbeats, input bit clr_first);
    int n, g;
    logic [7:0] e;
    logic ef;
    n = 0;
    cur = k;
    for (int r = 0; r < H[k]; r++) begin
      for (int c = 0; c < W[k]; c++) begin
        if (n == nbeats) return;
        set_in(k, 1'b1, img[r][c]);
        clr = clr_first && (n == 0);
        @(posedge clk); #1;
        set_in(k, 1'b0, 8'h00);
        clr = 1'b0;
        if (r % 2 == 1 && c % 2 == 1 && r < 2 * (H[k] / 2) && c < 2 * (W[k] / 2)) begin
          e  = m2(m2(img[r-1][c-1], img[r-1][c], k), m2(img[r][c-1], img[r][c], k), k);
          ef = (r == 2 * (H[k] / 2) - 1) && (c == 2 * (W[k] / 2) - 1);
          if (obs_v === 1'b1) outs.push_back(obs_p);
          chk("win_valid", obs_v, 1);
          chk("win_pool", obs_p, e);
          chk("win_fdone", obs_fd, ef);
          last[k] = e;
        end else begin
          idle_chk();
        end
        n++;
        g = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk); #1;
          idle_chk();
        end
      end
    end
  endtask

  task automatic chk_list(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    logic [7:0] ex [4];
    ex = '{a, b, c, d};
    chk({tag, "_count"}, 8'(outs.size()), 4);
    for (int i = 0; i < 4 && i < outs.size(); i++) chk({tag, "_val"}, outs[i], ex[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      cur = k;
      #1;
      chk("rst_valid", obs_v, 0);
      chk("rst_pool", obs_p, 0);
      chk("rst_fdone", obs_fd, 0);
      last[k] = 8'h00;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Ramp image: continuous, then every other cycle.
    fill_seq(0);
    outs.delete(); run(0, 0, 16, 0); chk_list("ramp", 5, 7, 13, 15);
    outs.delete(); run(0, 1, 16, 0); chk_list("ramp_gap", 5, 7, 13, 15);
    repeat (2) begin fill_rand(0); run(0, 2, 16, 0); end

    // Signed vs unsigned on the same window.
    fill_rand(1);
    img[0][0] = 8'hFF; img[0][1] = 8'h80; img[1][0] = 8'h01; img[1][1] = 8'hFE;
    outs.delete(); run(1, 0, 16, 0); chk("signed_win", outs.size() > 0 ? outs[0] : 8'hXX, 8'h01);
    outs.delete(); run(0, 0, 16, 0); chk("unsigned_win", outs.size() > 0 ? outs[0] : 8'hXX, 8'hFF);
    repeat (2) begin fill_rand(1); run(1, 2, 16, 0); end

    // Odd dimensions: last column and row drop out.
    fill_seq(2);
    outs.delete(); run(2, 0, 25, 0); chk_list("odd", 6, 8, 16, 18);
    fill_rand(2); run(2, 2, 25, 0);

    // Two 1-bit channels: OR-pool.
    img[0][0] = 8'h0; img[0][1] = 8'h0; img[1][0] = 8'h0; img[1][1] = 8'h1;
    outs.delete(); run(3, 0, 4, 0); chk("orpool", outs.size() > 0 ? outs[0] : 8'hXX, 8'h01);
    repeat (4) begin fill_rand(3); run(3, 2, 4, 0); end

    // Mid-frame reset, clr alone, and clr with valid.
    fill_seq(0);
    run(0, 0, 6, 0);
    do_reset();
    outs.delete(); run(0, 0, 16, 0); chk_list("after_rst", 5, 7, 13, 15);
    run(0, 0, 6, 0);
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    idle_chk();
    outs.delete(); run(0, 1, 16, 0); chk_list("after_clr", 5, 7, 13, 15);
    run(0, 0, 5, 0);
    outs.delete(); run(0, 0, 16, 1); chk_list("clr_valid", 5, 7, 13, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
